// File: rtl/tia_pkg.sv
// Shared constants and helpers for the TIA horizontal sync counter.
// Holds the phase width, the 6-bit step LFSR next-state function, the LFSR
// encodings of the decode points (steps 0, 4, 8, 16, 18, 56) and the
// LFSR-to-binary-index lookup.
package tia_pkg;

  localparam int PH_W   = 2;
  localparam int LFSR_W = 6;
  localparam int STEPS  = 57;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[4:0], ~(s[5] ^ s[4])};
  endfunction

  // Encoding reached after k advances from the all-zero seed.
  function automatic logic [LFSR_W-1:0] lfsr_at(input int k);
    logic [LFSR_W-1:0] s;
    s = '0;
    for (int i = 0; i < k; i++) s = lfsr_next(s);
    return s;
  endfunction

  localparam logic [LFSR_W-1:0] L_STEP0  = lfsr_at(0);
  localparam logic [LFSR_W-1:0] L_STEP4  = lfsr_at(4);
  localparam logic [LFSR_W-1:0] L_STEP8  = lfsr_at(8);
  localparam logic [LFSR_W-1:0] L_STEP16 = lfsr_at(16);
  localparam logic [LFSR_W-1:0] L_STEP18 = lfsr_at(18);
  localparam logic [LFSR_W-1:0] L_STEP56 = lfsr_at(56);

  // Binary step index of an LFSR state; walks the 57-entry sequence.
  function automatic logic [5:0] lfsr_to_idx(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] e;
    logic [5:0]        idx;
    e   = '0;
    idx = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (s == e) idx = 6'(i);
      e = lfsr_next(e);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tia_hsc_lfsr.sv
// Step-counter LFSR for the horizontal sync counter.
// Ports:
//   clk, rst_n : colour clock, asynchronous active-low reset
//   adv        : advance one step on this edge (last phase of a step)
//   clr        : synchronous return to the step-0 encoding (wins over adv)
//   q          : current LFSR state
//   wrap       : high while the state is the step-56 encoding
module tia_hsc_lfsr
  import tia_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              clr,
  output logic [LFSR_W-1:0] q,
  output logic              wrap
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  assign wrap = (q_q == L_STEP56);
  assign q    = q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = L_STEP0;
    end else if (adv) begin
      // Step 56 short-circuits back to the seed so a line is 57 steps.
      q_d = wrap ? L_STEP0 : lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= L_STEP0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/tia_hsc_ctl.sv
// TIA horizontal sync counter controller.
// Generates the two-phase step clocks, the 57-step line sequence and the
// registered line flags (hblank, hsync, line_start), the CPU ready line
// (WSYNC halt) and the HMOVE extended-blank latch.
// Ports:
//   clk, rst_n            : colour clock, asynchronous active-low reset
//   wsync, rsync, hmove   : one-clk CPU write strobes
//   hphi1, hphi2          : phase enables, ph==0 and ph==2
//   hstep                 : binary step index 0..56
//   hblank, hsync, rdy    : registered line flags and CPU ready
//   hmove_latch           : HMOVE pending / extended blank
//   line_start            : one-clk pulse at step 0, phase 0
module tia_hsc_ctl
  import tia_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wsync,
  input  logic       rsync,
  input  logic       hmove,
  output logic       hphi1,
  output logic       hphi2,
  output logic [5:0] hstep,
  output logic       hblank,
  output logic       hsync,
  output logic       rdy,
  output logic       hmove_latch,
  output logic       line_start
);

  logic [PH_W-1:0]   ph_q, ph_d;
  logic              hblank_q, hblank_d;
  logic              hsync_q, hsync_d;
  logic              rdy_q, rdy_d;
  logic              hmove_latch_q, hmove_latch_d;
  logic              line_start_q, line_start_d;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_nx;
  logic              lfsr_wrap;
  logic              adv;
  logic              ent0, ent4, ent8, ent16, ent18;

  assign adv     = (ph_q == PH_W'(3));
  assign lfsr_nx = lfsr_next(lfsr_q);

  tia_hsc_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (adv),
    .clr   (rsync),
    .q     (lfsr_q),
    .wrap  (lfsr_wrap)
  );

  // "Entering step k" = this edge advances the LFSR into the k encoding.
  assign ent0  = adv & lfsr_wrap;
  assign ent4  = adv & (lfsr_nx == L_STEP4);
  assign ent8  = adv & (lfsr_nx == L_STEP8);
  assign ent16 = adv & (lfsr_nx == L_STEP16);
  assign ent18 = adv & (lfsr_nx == L_STEP18);

  always_comb begin
    ph_d          = ph_q + PH_W'(1);
    hblank_d      = hblank_q;
    hsync_d       = hsync_q;
    rdy_d         = rdy_q;
    hmove_latch_d = hmove_latch_q;
    line_start_d  = 1'b0;
    if (rsync) begin
      // Forced line restart; behaves as an immediate entry into step 0.
      ph_d          = '0;
      hblank_d      = 1'b1;
      hsync_d       = 1'b0;
      line_start_d  = 1'b1;
      rdy_d         = 1'b1;
      hmove_latch_d = hmove;
    end else begin
      if (ent0) begin
        hblank_d      = 1'b1;
        line_start_d  = 1'b1;
        rdy_d         = 1'b1;
        hmove_latch_d = 1'b0;
      end
      // Blank end uses the latch as it stood before this edge, so a late
      // HMOVE never re-blanks a line whose blank already ended.
      if (ent16 && !hmove_latch_q) hblank_d = 1'b0;
      if (ent18 && hmove_latch_q)  hblank_d = 1'b0;
      if (ent4) hsync_d = 1'b1;
      if (ent8) hsync_d = 1'b0;
      // Strobes are applied last so they win over the line-start clear/set.
      if (wsync) rdy_d = 1'b0;
      if (hmove) hmove_latch_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q          <= '0;
      hblank_q      <= 1'b1;
      hsync_q       <= 1'b0;
      rdy_q         <= 1'b1;
      hmove_latch_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      ph_q          <= ph_d;
      hblank_q      <= hblank_d;
      hsync_q       <= hsync_d;
      rdy_q         <= rdy_d;
      hmove_latch_q <= hmove_latch_d;
      line_start_q  <= line_start_d;
    end
  end

  assign hphi1       = (ph_q == PH_W'(0));
  assign hphi2       = (ph_q == PH_W'(2));
  assign hstep       = lfsr_to_idx(lfsr_q);
  assign hblank      = hblank_q;
  assign hsync       = hsync_q;
  assign rdy         = rdy_q;
  assign hmove_latch = hmove_latch_q;
  assign line_start  = line_start_q;

endmodule

// File: tb/tb_tia_hsc_ctl.sv
// Bench for tia_hsc_ctl: a table of scenarios (input strobes plus one
// hand-derived spot expectation each) and a per-cycle scoreboard fed by a
// line-clock reference model.
module tb_tia_hsc_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wsync = 1'b0;
  logic       rsync = 1'b0;
  logic       hmove = 1'b0;
  logic       hphi1, hphi2, hblank, hsync, rdy, hmove_latch, line_start;
  logic [5:0] hstep;

  tia_hsc_ctl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wsync       (wsync),
    .rsync       (rsync),
    .hmove       (hmove),
    .hphi1       (hphi1),
    .hphi2       (hphi2),
    .hstep       (hstep),
    .hblank      (hblank),
    .hsync       (hsync),
    .rdy         (rdy),
    .hmove_latch (hmove_latch),
    .line_start  (line_start)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // {hstep, hsync, hblank, rdy, line_start, hmove_latch, hphi1, hphi2}
  typedef logic [12:0] obs_t;
  obs_t exp_q[$];

  typedef struct {
    int         n;
    int         rst_at;
    int         rsync_at;
    int         wsync_at;
    int         wsync_len;
    int         hmove_at;
    int         chk_t;
    logic       e_hsync;
    logic       e_hblank;
    logic       e_rdy;
    logic       e_ls;
    logic [5:0] e_hstep;
  } vec_t;
  vec_t vecs[$];

  // Reference model, expressed in line clocks 0..227.
  int   m_c;
  logic m_ls, m_rdy, m_latch, m_ext;

  function automatic vec_t mk(int n, int rst_at, int rsync_at, int wsync_at,
                              int wsync_len, int hmove_at, int chk_t,
                              logic hs, logic hb, logic rd, logic ls,
                              int st);
    vec_t v;
    v.n = n; v.rst_at = rst_at; v.rsync_at = rsync_at;
    v.wsync_at = wsync_at; v.wsync_len = wsync_len; v.hmove_at = hmove_at;
    v.chk_t = chk_t; v.e_hsync = hs; v.e_hblank = hb; v.e_rdy = rd;
    v.e_ls = ls; v.e_hstep = 6'(st);
    return v;
  endfunction

  function automatic obs_t dut_obs();
    return {hstep, hsync, hblank, rdy, line_start, hmove_latch, hphi1, hphi2};
  endfunction

  function automatic obs_t model_out();
    logic [5:0] st;
    logic       hs, hb;
    st = 6'(m_c / 4);
    hs = (m_c >= 16) && (m_c < 32);
    hb = (m_c < 64) || (m_ext && (m_c < 72));
    return {st, hs, hb, m_rdy, m_ls, m_latch, (m_c % 4) == 0, (m_c % 4) == 2};
  endfunction

  task automatic model_reset();
    m_c = 0; m_ls = 1'b0; m_rdy = 1'b1; m_latch = 1'b0; m_ext = 1'b0;
  endtask

  task automatic model_step(input logic w, input logic r, input logic h);
    if (r) begin
      m_c = 0; m_ls = 1'b1; m_rdy = 1'b1; m_latch = h; m_ext = 1'b0;
    end else begin
      m_c = (m_c == 227) ? 0 : m_c + 1;
      if (m_c == 64) m_ext = m_latch;
      m_ls = (m_c == 0);
      if (m_c == 0) begin
        m_rdy = 1'b1;
        m_latch = 1'b0;
      end
      if (w) m_rdy = 1'b0;
      if (h) m_latch = 1'b1;
    end
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    obs_t       e;
    logic       w, r, h, rel;
    logic [9:0] sp_act, sp_exp;
    wsync = 1'b0; rsync = 1'b0; hmove = 1'b0; rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    model_reset();
    exp_q.push_back(model_out());
    rel = 1'b1;
    for (int t = 0; t < v.n; t++) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_empty vec=%0d t=%0d: no expectation queued", vi, t);
      end else begin
        e = exp_q.pop_front();
        n_tests++;
        if (dut_obs() !== e) begin
          n_fail++;
          $display("FAIL sb vec=%0d t=%0d got=%b want=%b (hstep,hs,hb,rdy,ls,hml,p1,p2)",
                   vi, t, dut_obs(), e);
        end
      end
      if (t == v.chk_t) begin
        sp_act = {hsync, hblank, rdy, line_start, hstep};
        sp_exp = {v.e_hsync, v.e_hblank, v.e_rdy, v.e_ls, v.e_hstep};
        n_tests++;
        if (sp_act !== sp_exp) begin
          n_fail++;
          $display("FAIL spot vec=%0d t=%0d got=%b want=%b (hs,hb,rdy,ls,hstep)",
                   vi, t, sp_act, sp_exp);
        end
      end
      if (rel) begin
        rst_n = 1'b1;
        rel = 1'b0;
      end
      if (t == v.rst_at) begin
        wsync = 1'b0; rsync = 1'b0; hmove = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({hsync, hblank, line_start, hstep} !== {1'b0, 1'b1, 1'b0, 6'd0}) begin
          n_fail++;
          $display("FAIL async_rst vec=%0d t=%0d got hs=%b hb=%b ls=%b hstep=%0d want 0 1 0 0",
                   vi, t, hsync, hblank, line_start, hstep);
        end
        model_reset();
        exp_q.push_back(model_out());
        rel = 1'b1;
      end else begin
        w = (v.wsync_at >= 0) && (t >= v.wsync_at) && (t < v.wsync_at + v.wsync_len);
        r = (t == v.rsync_at);
        h = (t == v.hmove_at);
        wsync = w; rsync = r; hmove = h;
        model_step(w, r, h);
        exp_q.push_back(model_out());
      end
      @(negedge clk);
    end
    wsync = 1'b0; rsync = 1'b0; hmove = 1'b0;
  endtask

  initial begin
    // n, rst, rsync, wsync, wlen, hmove, chk_t, hs, hb, rdy, ls, hstep
    // Free run: hsync clks 16..31, hblank 0..63, line_start every 228.
    vecs.push_back(mk(689, -1, -1, -1, 0, -1,  16, 1, 1, 1, 0,  4));
    vecs.push_back(mk(689, -1, -1, -1, 0, -1,  32, 0, 1, 1, 0,  8));
    vecs.push_back(mk(689, -1, -1, -1, 0, -1,  64, 0, 0, 1, 0, 16));
    vecs.push_back(mk(689, -1, -1, -1, 0, -1, 228, 0, 1, 1, 1,  0));
    vecs.push_back(mk(689, -1, -1, -1, 0, -1, 456, 0, 1, 1, 1,  0));
    // HMOVE at clk 10: blank extended to clk 71, next line normal.
    vecs.push_back(mk(470, -1, -1, -1, 0, 10,  71, 0, 1, 1, 0, 17));
    vecs.push_back(mk(470, -1, -1, -1, 0, 10,  72, 0, 0, 1, 0, 18));
    vecs.push_back(mk(470, -1, -1, -1, 0, 10, 292, 0, 0, 1, 0, 16));
    // WSYNC at clk 100.
    vecs.push_back(mk(470, -1, -1, 100, 1, -1, 101, 0, 0, 0, 0, 25));
    vecs.push_back(mk(470, -1, -1, 100, 1, -1, 227, 0, 0, 0, 0, 56));
    vecs.push_back(mk(470, -1, -1, 100, 1, -1, 228, 0, 1, 1, 1,  0));
    // WSYNC on the wrap clock: halts the whole next line.
    vecs.push_back(mk(689, -1, -1, 227, 1, -1, 228, 0, 1, 0, 1,  0));
    vecs.push_back(mk(689, -1, -1, 227, 1, -1, 455, 0, 0, 0, 0, 56));
    vecs.push_back(mk(689, -1, -1, 227, 1, -1, 456, 0, 1, 1, 1,  0));
    // RSYNC at clk 50, alone and together with WSYNC.
    vecs.push_back(mk(300, -1, 50, -1, 0, -1,  51, 0, 1, 1, 1,  0));
    vecs.push_back(mk(300, -1, 50, -1, 0, -1, 279, 0, 1, 1, 1,  0));
    vecs.push_back(mk(300, -1, 50, 50, 1, -1,  51, 0, 1, 1, 1,  0));
    // Async reset at clk 20 while hsync is high; restart from clk 21.
    vecs.push_back(mk(300, 20, -1, -1, 0, -1,  20, 1, 1, 1, 0,  5));
    vecs.push_back(mk(300, 20, -1, -1, 0, -1,  21, 0, 1, 1, 0,  0));
    vecs.push_back(mk(300, 20, -1, -1, 0, -1,  37, 1, 1, 1, 0,  4));
    vecs.push_back(mk(300, 20, -1, -1, 0, -1, 249, 0, 1, 1, 1,  0));
    // HMOVE after the blank ended: no retro-blank.
    vecs.push_back(mk(300, -1, -1, -1, 0, 66,  70, 0, 0, 1, 0, 17));
    // HMOVE on the clearing edge: latch survives, next line extended.
    vecs.push_back(mk(470, -1, -1, -1, 0, 227, 298, 0, 1, 1, 0, 17));
    vecs.push_back(mk(470, -1, -1, -1, 0, 227, 300, 0, 0, 1, 0, 18));
    // WSYNC held for five clks acts as one strobe.
    vecs.push_back(mk(300, -1, -1, 100, 5, -1, 105, 0, 0, 0, 0, 26));
    vecs.push_back(mk(300, -1, -1, 100, 5, -1, 228, 0, 1, 1, 1,  0));

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tia_hsc_ctl.md
TIA_HSC_CTL -- requirements
Module: tia_hsc_ctl

Interface
REQ-001 Parameters: none; all decode points are constants in the shared package.
REQ-002 clk  in  1  colour clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 wsync  in  1  one-clk strobe (CPU write to WSYNC).
REQ-005 rsync  in  1  one-clk strobe (CPU write to RSYNC).
REQ-006 hmove  in  1  one-clk strobe (CPU write to HMOVE).
REQ-007 hphi1  out  1  phase-1 enable, high one clk in four; feeds s1 of downstream DL latches.
REQ-008 hphi2  out  1  phase-2 enable, high one clk in four; feeds s2 of downstream DL latches.
REQ-009 hstep  out  6  current line step index, 0..56, binary.
REQ-010 hblank  out  1  horizontal blank.
REQ-011 hsync  out  1  horizontal sync.
REQ-012 rdy  out  1  CPU ready; low halts CPU.
REQ-013 hmove_latch  out  1  HMOVE pending/extended-blank flag.
REQ-014 line_start  out  1  one-clk pulse at start of each line.

Function
REQ-015 2-bit phase counter ph cycles 0,1,2,3,0; hphi1 = (ph==0), hphi2 = (ph==2), combinational from ph.
REQ-016 Step state: 6-bit LFSR, next = {q[4:0], q[5] XNOR q[4]}, seed 000000; when ph==3 the edge advances it, and from the step-56 encoding it returns to 000000 (57 steps, 228 clk per line).
REQ-017 hstep: binary index of LFSR state, from package decode; step k spans line clocks 4k..4k+3.
REQ-018 All flag outputs registered; they change on the edge entering the named step (ph becomes 0).
REQ-019 hblank: 1 entering step 0; 0 entering step 16 if hmove_latch==0, else entering step 18.
REQ-020 hsync: 1 entering step 4; 0 entering step 8.
REQ-021 line_start: 1 for the single clk with step 0, ph 0.
REQ-022 wsync: rdy 0 at next edge; rdy 1 at the edge entering step 0.
REQ-023 wsync on the same clk as the edge entering step 0 (natural wrap): wsync wins, rdy 0 for the whole next line.
REQ-024 rsync: next edge forces ph=0, LFSR=000000, hblank=1, hsync=0, line_start=1, rdy=1; rsync beats wsync on the same clk.
REQ-025 hmove: hmove_latch 1 at next edge; cleared entering step 0; hmove on the clearing edge leaves it 1 (set wins).
REQ-026 hmove while the line is in steps 16..17 with hblank already 0: no retro-blank; extension applies from next line.
REQ-027 wsync held multiple clks acts as one strobe; rdy stays 0 until release.

Reset
REQ-028 While rst_n low: ph=0, LFSR=000000, hstep=0, hblank=1, hsync=0, rdy=1, hmove_latch=0, line_start=0, hphi1=1, hphi2=0.
REQ-029 First edge after rst_n rises: ph=1, step 0 continues; the first line is 228 clk from the reset release.
REQ-030 Reset mid-line abandons the line; no partial hsync pulse survives reset.

Structure
REQ-031 Shared package tia_pkg holds: 6-bit LFSR encodings for steps 0, 4, 8, 16, 18, 56; the LFSR-to-index table; the phase width.
REQ-032 One sub-module tia_hsc_lfsr: LFSR register, advance enable, sync reset, wrap detect.
REQ-033 Controller owns phase, flags, rdy and the hmove latch.

Verification
REQ-034 Reset release, free run 3 lines -> line_start every 228 clk; hsync high clks 16..31; hblank high clks 0..63.
REQ-035 hmove at clk 10 -> hblank high clks 0..71 that line; next line is 0..63 again.
REQ-036 wsync at clk 100 -> rdy 0 from clk 101 through clk 227; rdy 1 at clk 0 of the next line.
REQ-037 wsync on clk 227 -> rdy 0 for the entire following line; rdy 1 at its end.
REQ-038 rsync at clk 50 -> line_start at clk 51, hstep 0, hsync still 0; the next line_start is 228 clk later.
REQ-039 rst_n low at clk 20 (hsync high) -> hsync 0 and hblank 1 immediately, asynchronous; the sequence restarts from step 0.
